// File: rtl/mxrv_csr_access_if.sv
// CSR register-file bus: the access block is the master, the CSR file the slave.
// Read data is registered in the CSR file and returns one cycle after the address.
interface mxrv_csr_access_if #(
   parameter int XLEN   = 32,
   parameter int CSR_AW = 12
);
   logic [CSR_AW-1:0] csr_addr_o;
   logic              csr_we_o;
   logic [XLEN-1:0]   csr_wdata_o;
   logic [XLEN-1:0]   csr_rdata_i;

   modport master (
      output csr_addr_o,
      output csr_we_o,
      output csr_wdata_o,
      input  csr_rdata_i
   );

   modport slave (
      input  csr_addr_o,
      input  csr_we_o,
      input  csr_wdata_o,
      output csr_rdata_i
   );
endinterface

// File: rtl/mxrv_csr_access.sv
// Zicsr execute-side initiator: decode, read (1-cycle), read-modify-write, rd return.
// Optional MXRV_CSR_ERRWORD_EN: a read returning ERROR_WORD retires as illegal.
module mxrv_csr_access #(
   parameter int              XLEN       = 32,
   parameter int              CSR_AW     = 12,
   parameter logic [XLEN-1:0] ERROR_WORD = 32'hFFFF_FFFF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              inst_valid_i,
   input  logic [31:0]       inst_i,
   input  logic [XLEN-1:0]   rs1_data_i,
   output logic              ready_o,
   input  logic              flush_i,
   mxrv_csr_access_if.master csr_bus,
   output logic              rd_we_o,
   output logic [4:0]        rd_addr_o,
   output logic [XLEN-1:0]   rd_wdata_o,
   output logic              done_o,
   output logic              illegal_o,
   output logic              inst_succ_o,
   output logic [2:0]        o_dbg_state
);

`ifdef MXRV_CSR_ERRWORD_EN
   localparam bit LP_ERRWORD_EN = 1'b1;
`else
   localparam bit LP_ERRWORD_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_CAPT  = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t            r_state;
   logic [1:0]        r_op;
   logic [4:0]        r_rd;
   logic [CSR_AW-1:0] r_addr;
   logic [XLEN-1:0]   r_src;
   logic [XLEN-1:0]   r_old;
   logic              r_skip_write;
   logic              r_did_read;

   logic              r_ready;
   logic [CSR_AW-1:0] r_csr_addr;
   logic              r_csr_we;
   logic [XLEN-1:0]   r_csr_wdata;
   logic              r_done;
   logic              r_illegal;
   logic              r_succ;
   logic              r_rd_we;
   logic [4:0]        r_rd_addr;
   logic [XLEN-1:0]   r_rd_wdata;

   logic [6:0]        w_opcode;
   logic [2:0]        w_funct3;
   logic [4:0]        w_rd;
   logic [4:0]        w_rs1;
   logic [CSR_AW-1:0] w_addr;
   logic [XLEN-1:0]   w_src;
   logic [XLEN-1:0]   w_rdata;
   logic              w_is_rw;
   logic              w_skip_read;
   logic              w_skip_write;
   logic              w_illegal;
   logic              w_accept;
   logic              w_is_errword;

   assign w_opcode     = inst_i[6:0];
   assign w_rd         = inst_i[11:7];
   assign w_funct3     = inst_i[14:12];
   assign w_rs1        = inst_i[19:15];
   assign w_addr       = inst_i[31 -: CSR_AW];
   assign w_src        = w_funct3[2] ? {{(XLEN-5){1'b0}}, w_rs1} : rs1_data_i;
   assign w_is_rw      = (w_funct3[1:0] == 2'b01);
   assign w_skip_read  = w_is_rw & (w_rd == 5'd0);
   assign w_skip_write = ~w_is_rw & (w_rs1 == 5'd0);
   // Top two address bits 11 mark the read-only CSR space.
   assign w_illegal    = ~w_skip_write & (w_addr[CSR_AW-1 -: 2] == 2'b11);
   // funct3[1:0] == 00 covers both 000 (ECALL/EBREAK...) and 100 (reserved).
   assign w_accept     = inst_valid_i & r_ready & ~flush_i &
                         (w_opcode == 7'b1110011) & (w_funct3[1:0] != 2'b00);
   assign w_rdata      = csr_bus.csr_rdata_i;
   assign w_is_errword = (w_rdata == ERROR_WORD);

   function automatic logic [XLEN-1:0] f_new_val(input logic [1:0]      op,
                                                 input logic [XLEN-1:0] old,
                                                 input logic [XLEN-1:0] src);
      case (op)
         2'b01:   f_new_val = src;
         2'b10:   f_new_val = old | src;
         default: f_new_val = old & ~src;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_op         <= 2'b00;
         r_rd         <= 5'd0;
         r_addr       <= '0;
         r_src        <= '0;
         r_old        <= '0;
         r_skip_write <= 1'b0;
         r_did_read   <= 1'b0;
         r_ready      <= 1'b1;
         r_csr_addr   <= '0;
         r_csr_we     <= 1'b0;
         r_csr_wdata  <= '0;
         r_done       <= 1'b0;
         r_illegal    <= 1'b0;
         r_succ       <= 1'b0;
         r_rd_we      <= 1'b0;
         r_rd_addr    <= 5'd0;
         r_rd_wdata   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_op         <= w_funct3[1:0];
                  r_rd         <= w_rd;
                  r_addr       <= w_addr;
                  r_src        <= w_src;
                  r_skip_write <= w_skip_write;
                  r_old        <= '0;
                  r_did_read   <= 1'b0;
                  r_ready      <= 1'b0;
                  if (w_illegal) begin
                     r_state    <= S_DONE;
                     r_done     <= 1'b1;
                     r_illegal  <= 1'b1;
                     r_succ     <= 1'b0;
                     r_rd_we    <= 1'b0;
                     r_rd_addr  <= w_rd;
                     r_rd_wdata <= '0;
                  end else if (w_skip_read) begin
                     r_state     <= S_WRITE;
                     r_csr_addr  <= w_addr;
                     r_csr_we    <= 1'b1;
                     r_csr_wdata <= w_src;
                  end else begin
                     r_state    <= S_READ;
                     r_csr_addr <= w_addr;
                     r_csr_we   <= 1'b0;
                  end
               end
            end
            S_READ: begin
               r_csr_addr <= '0;
               if (flush_i) begin
                  r_state <= S_IDLE;
                  r_ready <= 1'b1;
               end else begin
                  r_state <= S_CAPT;
               end
            end
            S_CAPT: begin
               if (flush_i) begin
                  r_state <= S_IDLE;
                  r_ready <= 1'b1;
               end else begin
                  r_old      <= w_rdata;
                  r_did_read <= 1'b1;
                  if (LP_ERRWORD_EN && w_is_errword) begin
                     r_state    <= S_DONE;
                     r_done     <= 1'b1;
                     r_illegal  <= 1'b1;
                     r_succ     <= 1'b0;
                     r_rd_we    <= 1'b0;
                     r_rd_addr  <= r_rd;
                     r_rd_wdata <= w_rdata;
                  end else if (r_skip_write) begin
                     r_state    <= S_DONE;
                     r_done     <= 1'b1;
                     r_succ     <= 1'b1;
                     r_rd_we    <= (r_rd != 5'd0);
                     r_rd_addr  <= r_rd;
                     r_rd_wdata <= w_rdata;
                  end else begin
                     // Old value is modified straight off the read bus; r_old lands the same edge.
                     r_state     <= S_WRITE;
                     r_csr_addr  <= r_addr;
                     r_csr_we    <= 1'b1;
                     r_csr_wdata <= f_new_val(r_op, w_rdata, r_src);
                  end
               end
            end
            S_WRITE: begin
               r_state     <= S_DONE;
               r_csr_addr  <= '0;
               r_csr_we    <= 1'b0;
               r_csr_wdata <= '0;
               r_done      <= 1'b1;
               r_succ      <= 1'b1;
               r_rd_we     <= r_did_read & (r_rd != 5'd0);
               r_rd_addr   <= r_rd;
               r_rd_wdata  <= r_old;
            end
            S_DONE: begin
               r_state    <= S_IDLE;
               r_ready    <= 1'b1;
               r_done     <= 1'b0;
               r_illegal  <= 1'b0;
               r_succ     <= 1'b0;
               r_rd_we    <= 1'b0;
               r_rd_addr  <= 5'd0;
               r_rd_wdata <= '0;
            end
            default: begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign ready_o             = r_ready;
   assign csr_bus.csr_addr_o  = r_csr_addr;
   assign csr_bus.csr_we_o    = r_csr_we;
   assign csr_bus.csr_wdata_o = r_csr_wdata;
   assign done_o              = r_done;
   assign illegal_o           = r_illegal;
   assign inst_succ_o         = r_succ;
   assign rd_we_o             = r_rd_we;
   assign rd_addr_o           = r_rd_addr;
   assign rd_wdata_o          = r_rd_wdata;
   assign o_dbg_state         = r_state;

endmodule
